// File: rtl/spi_port_pkg.sv
// spi_port_pkg: register map, bit indices and engine states shared by the SPI port.
package spi_port_pkg;
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL = 3'd2;
  localparam logic [2:0] ADDR_DIV = 3'd3;
  localparam int ST_BUSY = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_AVAIL = 3;
  localparam int ST_RX_FULL = 4;
  localparam int ST_OVERRUN = 5;
  localparam int CTRL_CPOL = 0;
  localparam int CTRL_CPHA = 1;
  localparam int CTRL_CS = 2;
  localparam int CTRL_IRQ_TX = 3;
  localparam int CTRL_IRQ_RX = 4;
  localparam int CTRL_CLR_OVR = 7;
  localparam int FIFO_DEPTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
endpackage

// File: rtl/spi_port_if.sv
// spi_port_if: peripheral bus between the CPU core (master) and the SPI port (slave).
interface spi_port_if;
  logic bus_cyc;
  logic bus_we;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic irq4;
  modport master(output bus_cyc, bus_we, addr, data_in, input data_out, irq4);
  modport slave(input bus_cyc, bus_we, addr, data_in, output data_out, irq4);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic full,
  output logic empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + ONE;
      end
      if (pop && !empty) rp <= rp + ONE;
    end
  end
endmodule

// File: rtl/spi_port.sv
// spi_port: byte-oriented SPI master on the core peripheral bus with TX/RX FIFOs and irq4.
module spi_port
  import spi_port_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [7:0] DIV_RESET = 8'h03
) (
  input  logic wb_clk_i,
  input  logic rst,
  spi_port_if.slave bus,
  output logic spi_sck,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic spi_cs_n
);
  state_t state;
  logic [4:0] ctrl;
  logic [7:0] div, div_w, div_cnt, sh, rx_sr, tx_head, rx_head, status;
  logic [3:0] edge_cnt;
  logic cpha_w, overrun, irq, tx_full, tx_empty, rx_full, rx_empty;
  logic wr, rd, busy, term, drive;
  assign wr = bus.bus_cyc & bus.bus_we;
  assign rd = bus.bus_cyc & ~bus.bus_we;
  assign busy = state != IDLE || !tx_empty;
  assign term = div_cnt == div_w;
  assign drive = edge_cnt[0] ^ cpha_w;
  assign spi_cs_n = ~ctrl[CTRL_CS];
  assign bus.irq4 = irq;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(wb_clk_i), .rst(rst), .push(wr && bus.addr == ADDR_DATA), .pop(state == IDLE),
    .din(bus.data_in), .full(tx_full), .empty(tx_empty), .head(tx_head)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(wb_clk_i), .rst(rst), .push(state == DONE && !rx_full), .pop(rd && bus.addr == ADDR_DATA),
    .din(rx_sr), .full(rx_full), .empty(rx_empty), .head(rx_head)
  );
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_AVAIL] = !rx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_OVERRUN] = overrun;
    bus.data_out = bus.addr == ADDR_DATA ? (rx_empty ? 8'h00 : rx_head) :
                   bus.addr == ADDR_STATUS ? status :
                   bus.addr == ADDR_CTRL ? {3'b000, ctrl} :
                   bus.addr == ADDR_DIV ? div : 8'h00;
  end
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state <= IDLE;
      ctrl <= '0;
      div <= DIV_RESET;
      div_w <= '0;
      div_cnt <= '0;
      edge_cnt <= '0;
      sh <= '0;
      rx_sr <= '0;
      cpha_w <= 1'b0;
      overrun <= 1'b0;
      irq <= 1'b0;
      spi_sck <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      if (wr && bus.addr == ADDR_CTRL) ctrl <= bus.data_in[4:0];
      if (wr && bus.addr == ADDR_DIV) div <= bus.data_in;
      if (state == DONE && rx_full) overrun <= 1'b1;
      else if (wr && bus.addr == ADDR_CTRL && bus.data_in[CTRL_CLR_OVR]) overrun <= 1'b0;
      irq <= (ctrl[CTRL_IRQ_TX] & tx_empty & ~busy) | (ctrl[CTRL_IRQ_RX] & ~rx_empty);
      case (state)
        IDLE: begin
          spi_sck <= ctrl[CTRL_CPOL];
          if (!tx_empty) begin
            // sh holds the next bit to drive in [7]; cpha=0 puts the MSB out at load
            state <= XFER;
            div_w <= div;
            cpha_w <= ctrl[CTRL_CPHA];
            div_cnt <= '0;
            edge_cnt <= '0;
            sh <= ctrl[CTRL_CPHA] ? tx_head : {tx_head[6:0], 1'b0};
            spi_mosi <= ctrl[CTRL_CPHA] ? spi_mosi : tx_head[7];
          end
        end
        XFER: begin
          div_cnt <= term ? 8'd0 : div_cnt + 8'd1;
          if (term) begin
            spi_sck <= ~spi_sck;
            edge_cnt <= edge_cnt + 4'd1;
            if (drive) begin
              spi_mosi <= sh[7];
              sh <= {sh[6:0], 1'b0};
            end else rx_sr <= {rx_sr[6:0], spi_miso};
            if (edge_cnt == 4'd15) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_port.sv
// tb_spi_port: directed self-checking bench for spi_port.
module tb_spi_port;
  import spi_port_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic spi_sck, spi_mosi, spi_miso, spi_cs_n;
  logic loop = 1'b0, miso_val = 1'b0;
  int n_cmp = 0, n_bad = 0, sck_toggles = 0;
  spi_port_if bus();
  spi_port #(.FIFO_DEPTH(4), .DIV_RESET(8'h03)) dut (
    .wb_clk_i(clk), .rst(rst), .bus(bus),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );
  assign spi_miso = loop ? spi_mosi : miso_val;
  always #5 clk = ~clk;
  always @(spi_sck) sck_toggles++;

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.bus_cyc = 1'b1; bus.bus_we = 1'b1; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.bus_cyc = 1'b0; bus.bus_we = 1'b0;
  endtask

  task automatic pop_data(output logic [7:0] d);
    @(negedge clk);
    bus.bus_cyc = 1'b1; bus.bus_we = 1'b0; bus.addr = ADDR_DATA;
    #1 d = bus.data_out;
    @(negedge clk);
    bus.bus_cyc = 1'b0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] d);
    bus.bus_cyc = 1'b0; bus.addr = a;
    #1 d = bus.data_out;
  endtask

  task automatic wait_idle(output bit ok);
    logic [7:0] st;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      peek(ADDR_STATUS, st);
      ok = !st[ST_BUSY];
    end
  endtask

  task automatic watch_byte(input logic cpol, input logic cpha, input int gap, output int edges,
                            output logic [7:0] bits, output int first, output int gap_err);
    logic prev;
    int last, cyc;
    prev = spi_sck; edges = 0; bits = '0; first = -1; gap_err = 0; last = 0; cyc = 0;
    while (edges < 16 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (spi_sck !== prev) begin
        edges++;
        if (edges == 1) first = cyc;
        else if (cyc - last != gap) gap_err++;
        last = cyc;
        if ((spi_sck != cpol) ^ cpha) bits = {bits[6:0], spi_mosi};
        prev = spi_sck;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic [7:0] exp [8] = '{8'h00, 8'h04, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    bus.bus_cyc = 1'b0; bus.bus_we = 1'b0; bus.addr = '0; bus.data_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      peek(3'(a), d);
      n_cmp++;
      if (d !== exp[a]) begin n_bad++; $display("FAIL reset_read addr%0d: got %h want %h", a, d, exp[a]); end
    end
    n_cmp++;
    if ({spi_cs_n, spi_sck, spi_mosi, bus.irq4} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_pins cs_n/sck/mosi/irq: got %b want 1000", {spi_cs_n, spi_sck, spi_mosi, bus.irq4});
    end
  endtask

  task automatic test_mode0;
    int edges, first, gap_err;
    logic [7:0] bits, d;
    bit ok;
    loop = 1'b1;
    bus_write(ADDR_CTRL, 8'h04);
    bus_write(ADDR_DIV, 8'h00);
    n_cmp++;
    if (spi_cs_n !== 1'b0) begin n_bad++; $display("FAIL mode0_cs: got %b want 0", spi_cs_n); end
    bus_write(ADDR_DATA, 8'hA5);
    watch_byte(1'b0, 1'b0, 1, edges, bits, first, gap_err);
    n_cmp++;
    if (edges !== 16) begin n_bad++; $display("FAIL mode0_edges: got %0d want 16", edges); end
    n_cmp++;
    if (first !== 2) begin n_bad++; $display("FAIL mode0_first_edge: got %0d want 2", first); end
    n_cmp++;
    if (gap_err !== 0) begin n_bad++; $display("FAIL mode0_gap: got %0d bad gaps want 0", gap_err); end
    n_cmp++;
    if (bits !== 8'hA5) begin n_bad++; $display("FAIL mode0_mosi: got %h want a5", bits); end
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mode0_idle: got busy want idle"); end
    pop_data(d);
    n_cmp++;
    if (d !== 8'hA5) begin n_bad++; $display("FAIL mode0_rx: got %h want a5", d); end
    peek(ADDR_STATUS, d);
    n_cmp++;
    if (d[ST_RX_AVAIL] !== 1'b0) begin n_bad++; $display("FAIL mode0_rx_avail: got %b want 0", d[ST_RX_AVAIL]); end
  endtask

  task automatic test_mode3;
    int edges, first, gap_err;
    logic [7:0] bits, d;
    bit ok;
    loop = 1'b0; miso_val = 1'b1;
    bus_write(ADDR_CTRL, 8'h07);
    bus_write(ADDR_DIV, 8'h02);
    n_cmp++;
    if (spi_sck !== 1'b1) begin n_bad++; $display("FAIL mode3_idle_sck: got %b want 1", spi_sck); end
    bus_write(ADDR_DATA, 8'h3C);
    watch_byte(1'b1, 1'b1, 3, edges, bits, first, gap_err);
    n_cmp++;
    if (edges !== 16 || first !== 4 || gap_err !== 0) begin
      n_bad++; $display("FAIL mode3_sck: got edges %0d first %0d badgaps %0d want 16 4 0", edges, first, gap_err);
    end
    n_cmp++;
    if (bits !== 8'h3C) begin n_bad++; $display("FAIL mode3_mosi: got %h want 3c", bits); end
    wait_idle(ok);
    n_cmp++;
    if (!ok || spi_sck !== 1'b1) begin n_bad++; $display("FAIL mode3_end: got idle %b sck %b want 1 1", ok, spi_sck); end
    pop_data(d);
    n_cmp++;
    if (d !== 8'hFF) begin n_bad++; $display("FAIL mode3_rx: got %h want ff", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d, st;
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bit ok;
    loop = 1'b1;
    bus_write(ADDR_CTRL, 8'h04);
    bus_write(ADDR_DIV, 8'h00);
    repeat (2) @(posedge clk);
    sck_toggles = 0;
    for (int i = 1; i <= 5; i++) bus_write(ADDR_DATA, 8'(i * 8'h11));
    peek(ADDR_STATUS, st);
    n_cmp++;
    if (st[ST_TX_FULL] !== 1'b1) begin n_bad++; $display("FAIL b2b_tx_full: got %b want 1", st[ST_TX_FULL]); end
    bus_write(ADDR_DATA, 8'h66);
    wait_idle(ok);
    n_cmp++;
    if (!ok || sck_toggles !== 80) begin n_bad++; $display("FAIL b2b_toggles: got %0d idle %b want 80 1", sck_toggles, ok); end
    peek(ADDR_STATUS, st);
    n_cmp++;
    if (st !== 8'h3C) begin n_bad++; $display("FAIL b2b_overrun_status: got %h want 3c", st); end
    bus_write(ADDR_CTRL, 8'h84);
    peek(ADDR_STATUS, st);
    n_cmp++;
    if (st !== 8'h1C) begin n_bad++; $display("FAIL b2b_clear_status: got %h want 1c", st); end
    peek(ADDR_CTRL, st);
    n_cmp++;
    if (st !== 8'h04) begin n_bad++; $display("FAIL b2b_ctrl_read: got %h want 04", st); end
    for (int i = 0; i < 4; i++) begin
      pop_data(d);
      n_cmp++;
      if (d !== exp[i]) begin n_bad++; $display("FAIL b2b_rx%0d: got %h want %h", i, d, exp[i]); end
    end
    peek(ADDR_STATUS, st);
    n_cmp++;
    if (st !== 8'h04) begin n_bad++; $display("FAIL b2b_final_status: got %h want 04", st); end
  endtask

  task automatic test_irq;
    logic [7:0] st, d;
    bit seen = 1'b0;
    bus_write(ADDR_CTRL, 8'h14);
    n_cmp++;
    if (bus.irq4 !== 1'b0) begin n_bad++; $display("FAIL irq_rx_quiet: got %b want 0", bus.irq4); end
    bus_write(ADDR_DATA, 8'h5A);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      peek(ADDR_STATUS, st);
      seen = st[ST_RX_AVAIL];
    end
    n_cmp++;
    if (!seen || bus.irq4 !== 1'b0) begin n_bad++; $display("FAIL irq_rx_lag: got avail %b irq %b want 1 0", seen, bus.irq4); end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.irq4 !== 1'b1) begin n_bad++; $display("FAIL irq_rx_rise: got %b want 1", bus.irq4); end
    pop_data(d);
    n_cmp++;
    if (d !== 8'h5A || bus.irq4 !== 1'b1) begin n_bad++; $display("FAIL irq_rx_pop: got data %h irq %b want 5a 1", d, bus.irq4); end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.irq4 !== 1'b0) begin n_bad++; $display("FAIL irq_rx_fall: got %b want 0", bus.irq4); end
    bus_write(ADDR_CTRL, 8'h0C);
    @(posedge clk); #1;
    n_cmp++;
    if (bus.irq4 !== 1'b1) begin n_bad++; $display("FAIL irq_tx_idle: got %b want 1", bus.irq4); end
    bus_write(ADDR_CTRL, 8'h04);
    @(posedge clk); #1;
    n_cmp++;
    if (bus.irq4 !== 1'b0) begin n_bad++; $display("FAIL irq_off: got %b want 0", bus.irq4); end
  endtask

  task automatic test_rst_mid;
    logic [7:0] st;
    logic prev;
    int edges = 0;
    loop = 1'b1;
    bus_write(ADDR_DATA, 8'h81);
    prev = spi_sck;
    for (int i = 0; i < 100 && edges < 7; i++) begin
      @(posedge clk); #1;
      if (spi_sck !== prev) edges++;
      prev = spi_sck;
    end
    n_cmp++;
    if (edges !== 7 || spi_sck !== 1'b1) begin n_bad++; $display("FAIL rst_mid_reach: got edges %0d sck %b want 7 1", edges, spi_sck); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (spi_sck !== 1'b0 || spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pins: got sck %b cs_n %b want 0 1", spi_sck, spi_cs_n); end
    peek(ADDR_STATUS, st);
    n_cmp++;
    if (st !== 8'h04) begin n_bad++; $display("FAIL rst_mid_status: got %h want 04", st); end
    repeat (40) @(posedge clk);
    #1 peek(ADDR_STATUS, st);
    n_cmp++;
    if (st !== 8'h04) begin n_bad++; $display("FAIL rst_mid_no_rx: got %h want 04", st); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_irq();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
